dmem_responder: RTL and testbench

- Data-memory target that sits on the core's load/store port, opposite the PC/fetch stall logic.
- Accepts one load or store request at a time and inserts LATENCY wait cycles.
- Performs the access on an internal word array.
- Returns a one-cycle dmem_valid pulse, which releases the core's load stall.
- Flags misaligned and out-of-range accesses instead of performing them.

---
 rtl/dmem_responder.sv | 178 +++++++++++++++++
 tb/tb_dmem_responder.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding data-memory target for the core's
// load/store port. A request is latched, held for LATENCY wait cycles, then
// performed on an internal word array on the edge that enters RESP. The
// response is a one-cycle dmem_valid pulse with registered rdata and err.
// Misaligned or out-of-range accesses are flagged and never performed.
module dmem_responder #(
    parameter int DEPTH   = 1024,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dmem_req,
    input  logic        dmem_we,
    input  logic [31:0] dmem_addr,
    input  logic [31:0] dmem_wdata,
    input  logic [3:0]  dmem_wstrb,
    output logic        dmem_valid,
    output logic [31:0] dmem_rdata,
    output logic        dmem_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        valid_q, valid_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    // Latched request fields (payload only, no reset needed)
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;

    logic [31:0] mem [DEPTH];

    // Fields used on the access edge. With LATENCY=0 the access edge is the
    // acceptance edge, so the live request inputs are used while in IDLE.
    logic          acc_we;
    logic [31:0]   acc_addr;
    logic [31:0]   acc_wdata;
    logic [3:0]    acc_wstrb;
    logic          acc_fault;
    logic [AW-1:0] acc_idx;
    logic          access;
    logic          mem_wr;

    // Select the access fields and classify the access as faulting or not
    always_comb begin
        if (state_q == IDLE) begin
            acc_we    = dmem_we;
            acc_addr  = dmem_addr;
            acc_wdata = dmem_wdata;
            acc_wstrb = dmem_wstrb;
        end else begin
            acc_we    = we_q;
            acc_addr  = addr_q;
            acc_wdata = wdata_q;
            acc_wstrb = wstrb_q;
        end
        acc_fault = (acc_addr[1:0] != 2'b00) ||
                    ({2'b00, acc_addr[31:2]} >= 32'(DEPTH));
        acc_idx   = acc_addr[AW+1:2];
    end

    // Next-state, wait counter, request latching and response generation
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        rdata_d = rdata_q;
        err_d   = err_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        access  = 1'b0;

        case (state_q)
            IDLE: begin
                if (dmem_req) begin
                    we_d    = dmem_we;
                    addr_d  = dmem_addr;
                    wdata_d = dmem_wdata;
                    wstrb_d = dmem_wstrb;
                    cnt_d   = 4'(LATENCY);
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    state_d = RESP;
                end
            end
            RESP: begin
                // The req still asserted here belongs to the finished access
                state_d = IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if ((state_d == RESP) && (state_q != RESP)) begin
            access  = 1'b1;
            valid_d = 1'b1;
            if (acc_fault) begin
                rdata_d = 32'h0;
                err_d   = 1'b1;
            end else if (acc_we) begin
                rdata_d = 32'h0;
                err_d   = 1'b0;
            end else begin
                rdata_d = mem[acc_idx];
                err_d   = 1'b0;
            end
        end
    end

    // Stores commit only on the access edge and never while reset is held
    assign mem_wr = access && acc_we && !acc_fault && rst;

    // Control and response registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            valid_q <= 1'b0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request payload registers
    always_ff @(posedge clk) begin
        we_q    <= we_d;
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        wstrb_q <= wstrb_d;
    end

    // Byte-lane write into the word array; unselected lanes keep their data
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_wstrb[b]) begin
                    mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
                end
            end
        end
    end

    assign dmem_valid = valid_q;
    assign dmem_rdata = rdata_q;
    assign dmem_err   = err_q;
    assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized loads/stores
// checked against a word-indexed reference memory. Instance A uses
// LATENCY=2, instance B uses LATENCY=0 for the back-to-back scenario.
module tb_dmem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT_A = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        a_rst, a_req, a_we, a_valid, a_err, a_busy;
    logic [31:0] a_addr, a_wdata, a_rdata;
    logic [3:0]  a_wstrb;
    logic        b_rst, b_req, b_we, b_valid, b_err, b_busy;
    logic [31:0] b_addr, b_wdata, b_rdata;
    logic [3:0]  b_wstrb;

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT_A)) u_a (
        .clk(clk), .rst(a_rst), .dmem_req(a_req), .dmem_we(a_we),
        .dmem_addr(a_addr), .dmem_wdata(a_wdata), .dmem_wstrb(a_wstrb),
        .dmem_valid(a_valid), .dmem_rdata(a_rdata), .dmem_err(a_err),
        .busy(a_busy)
    );

    dmem_responder #(.DEPTH(DEPTH), .LATENCY(0)) u_b (
        .clk(clk), .rst(b_rst), .dmem_req(b_req), .dmem_we(b_we),
        .dmem_addr(b_addr), .dmem_wdata(b_wdata), .dmem_wstrb(b_wstrb),
        .dmem_valid(b_valid), .dmem_rdata(b_rdata), .dmem_err(b_err),
        .busy(b_busy)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ref_mem [int unsigned];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference behaviour: fault on misalignment or word index past DEPTH,
    // otherwise byte-masked store or whole-word load.
    task automatic model(input logic we, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         output logic [31:0] erd, output logic eer);
        int unsigned w;
        logic [31:0] word;
        w = addr / 4;
        if ((addr % 4) != 0 || w >= DEPTH) begin
            erd = 32'h0;
            eer = 1'b1;
        end else if (we) begin
            word = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (wstrb[b]) word[8*b +: 8] = wdata[8*b +: 8];
            ref_mem[w] = word;
            erd = 32'h0;
            eer = 1'b0;
        end else begin
            erd = ref_mem.exists(w) ? ref_mem[w] : 32'h0;
            eer = 1'b0;
        end
    endtask

    // One transaction on instance A with timing, pulse and hold checks
    task automatic txn(input string tag, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] wstrb);
        logic [31:0] erd, rd;
        logic        eer, er, got;
        int          lat, i;
        model(we, addr, wdata, wstrb, erd, eer);
        @(negedge clk);
        a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; a_wstrb = wstrb;
        got = 1'b0; lat = 0; i = 0; rd = 32'h0; er = 1'b0;
        while (!got && i < 20) begin
            @(negedge clk);
            i++;
            if (i <= LAT_A + 1) chk({tag, "_busy"}, 32'(a_busy), 32'd1);
            if (a_valid) begin
                got = 1'b1; lat = i; rd = a_rdata; er = a_err;
                a_req = 1'b0;
            end
        end
        if (!got) begin
            a_req = 1'b0;
            chk({tag, "_timeout"}, 32'd0, 32'd1);
        end
        chk({tag, "_lat"}, 32'(lat), 32'(LAT_A + 1));
        chk({tag, "_rdata"}, rd, erd);
        chk({tag, "_err"}, 32'(er), 32'(eer));
        @(negedge clk);
        chk({tag, "_pulse"}, 32'(a_valid), 32'd0);
        chk({tag, "_errclr"}, 32'(a_err), 32'd0);
        chk({tag, "_idle"}, 32'(a_busy), 32'd0);
        chk({tag, "_hold"}, a_rdata, rd);
    endtask

    initial begin
        logic [31:0] addr;
        int k;
        a_rst = 1'b0; a_req = 1'b0; a_we = 1'b0; a_addr = 32'h0; a_wdata = 32'h0; a_wstrb = 4'h0;
        b_rst = 1'b0; b_req = 1'b0; b_we = 1'b0; b_addr = 32'h0; b_wdata = 32'h0; b_wstrb = 4'h0;
        #12;
        chk("rst_valid", 32'(a_valid), 32'd0);
        chk("rst_rdata", a_rdata, 32'h0);
        chk("rst_err", 32'(a_err), 32'd0);
        chk("rst_busy", 32'(a_busy), 32'd0);
        chk("rst_b_busy", 32'(b_busy), 32'd0);
        @(negedge clk);
        a_rst = 1'b1; b_rst = 1'b1;

        // Full store then load, byte-lane merge, empty strobe
        txn("st_full", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        txn("ld_full", 1'b0, 32'h10, 32'h0, 4'h0);
        txn("st_lane1", 1'b1, 32'h10, 32'h0000AA00, 4'b0010);
        txn("ld_lane1", 1'b0, 32'h10, 32'h0, 4'h0);
        txn("st_nostrb", 1'b1, 32'h10, 32'h11111111, 4'h0);
        txn("ld_nostrb", 1'b0, 32'h10, 32'h0, 4'h0);

        // Misaligned and out-of-range faults
        txn("ld_mis", 1'b0, 32'h13, 32'h0, 4'h0);
        txn("st_mis", 1'b1, 32'h12, 32'h12345678, 4'hF);
        txn("ld_after_mis", 1'b0, 32'h10, 32'h0, 4'h0);
        txn("ld_oor", 1'b0, 32'(4 * DEPTH), 32'h0, 4'h0);
        txn("st_top", 1'b1, 32'(4 * DEPTH - 4), 32'h0BADF00D, 4'hF);
        txn("ld_top", 1'b0, 32'(4 * DEPTH - 4), 32'h0, 4'h0);

        // Reset during WAIT aborts the store
        txn("st_pre20", 1'b1, 32'h20, 32'h11112222, 4'hF);
        txn("ld_pre20", 1'b0, 32'h20, 32'h0, 4'h0);
        @(negedge clk);
        a_req = 1'b1; a_we = 1'b1; a_addr = 32'h20; a_wdata = 32'hCAFEF00D; a_wstrb = 4'hF;
        @(negedge clk);
        chk("abort_inwait", 32'(a_busy), 32'd1);
        a_rst = 1'b0;
        #1;
        chk("abort_valid", 32'(a_valid), 32'd0);
        chk("abort_busy", 32'(a_busy), 32'd0);
        chk("abort_rdata", a_rdata, 32'h0);
        chk("abort_err", 32'(a_err), 32'd0);
        a_req = 1'b0;
        k = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (a_valid) k++;
        end
        chk("abort_novalid", 32'(k), 32'd0);
        a_rst = 1'b1;
        txn("ld_post20", 1'b0, 32'h20, 32'h0, 4'h0);

        // LATENCY=0, req held across two requests
        @(negedge clk);
        b_req = 1'b1; b_we = 1'b1; b_addr = 32'h40; b_wdata = 32'h5A5AC3C3; b_wstrb = 4'hF;
        @(negedge clk);
        chk("l0_v1", 32'(b_valid), 32'd1);
        chk("l0_e1", 32'(b_err), 32'd0);
        chk("l0_busy1", 32'(b_busy), 32'd1);
        b_we = 1'b0;
        @(negedge clk);
        chk("l0_gap_valid", 32'(b_valid), 32'd0);
        chk("l0_gap_busy", 32'(b_busy), 32'd0);
        @(negedge clk);
        chk("l0_v2", 32'(b_valid), 32'd1);
        chk("l0_rd2", b_rdata, 32'h5A5AC3C3);
        b_req = 1'b0;
        @(negedge clk);
        chk("l0_v3", 32'(b_valid), 32'd0);
        @(negedge clk);
        chk("l0_nodouble", 32'(b_valid), 32'd0);
        chk("l0_idle", 32'(b_busy), 32'd0);

        // Randomized traffic over an initialised pool of words
        for (int w = 0; w < 8; w++)
            txn("init", 1'b1, 32'h100 + 32'(4 * w), $urandom(), 4'hF);
        for (int n = 0; n < 60; n++) begin
            k = $urandom_range(0, 9);
            if (k == 0)
                addr = 32'h100 + 32'(4 * $urandom_range(0, 7)) + 32'($urandom_range(1, 3));
            else if (k == 1)
                addr = 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 255));
            else if (k == 2)
                addr = 32'(4 * DEPTH - 4);
            else
                addr = 32'h100 + 32'(4 * $urandom_range(0, 7));
            txn("rnd", 1'($urandom_range(0, 1)), addr, $urandom(), 4'($urandom_range(0, 15)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
